core_lsu_ctrl: RTL and testbench
================================

CORE_LSU_CTRL -- requirements
Module: core_lsu_ctrl

Interface
REQ-001 SHALL provide port CLK, input, 1, single clock; all state on rising edge.
REQ-002 SHALL provide port RST, input, 1, reset that is asynchronous and active-high.
REQ-003 SHALL provide port START, input, 1, one-cycle request pulse from pipeline control.
REQ-004 SHALL provide port WE, input, 1, 1 = store, 0 = load; sampled with START.
REQ-005 SHALL provide port ADDR, input, 32, effective data address; sampled with START.
REQ-006 SHALL provide port STRB, input, 4, byte-lane strobe (0001/0010/0100/1000, 0011/0110/1100, 1111); sampled with START.
REQ-007 SHALL provide port LOADUNS, input, 1, 1 = zero-extend load (LBU/LHU); sampled with START.
REQ-008 SHALL provide port WDATA, input, 32, unaligned store data (rs2, LSB-justified); sampled with START.
REQ-009 SHALL provide port BUSY, output, 1, transaction in progress.
REQ-010 SHALL provide port DONE, output, 1, one-cycle completion pulse.
REQ-011 SHALL provide port RDATA, output, 32, aligned and extended load result, valid with DONE.
REQ-012 SHALL provide port ERR, output, 1, response error flag, valid with DONE.
REQ-013 SHALL provide AXI4-Lite read master ports: M_ARADDR out 32, M_ARVALID out 1, M_ARREADY in 1, M_RDATA in 32, M_RRESP in 2, M_RVALID in 1, M_RREADY out 1.
REQ-014 SHALL provide AXI4-Lite write master ports: M_AWADDR out 32, M_AWVALID out 1, M_AWREADY in 1, M_WDATA out 32, M_WSTRB out 4, M_WVALID out 1, M_WREADY in 1, M_BRESP in 2, M_BVALID in 1, M_BREADY out 1.

Function
REQ-015 SHALL implement FSM states IDLE, AR, R, AWW, B; BUSY = 1 in every state except IDLE.
REQ-016 SHALL, in IDLE on START, latch WE, ADDR, STRB, LOADUNS and WDATA, then go to AR if WE = 0 or to AWW if WE = 1.
REQ-017 SHALL ignore START while BUSY = 1, with no latching and no queueing.
REQ-018 SHALL, on START with STRB = 0000, issue no bus transaction and pulse DONE on the next cycle with RDATA and ERR unchanged.
REQ-019 SHALL drive M_ARADDR/M_AWADDR with {ADDR[31:2], 2'b00} from the latched value, and hold it stable while the corresponding VALID is high.
REQ-020 SHALL, in AR, hold M_ARVALID = 1 until the M_ARREADY handshake, then go to R.
REQ-021 SHALL, in R, hold M_RREADY = 1; on M_RVALID go to IDLE and register the result.
REQ-022 SHALL, in AWW, assert M_AWVALID and M_WVALID together, deassert each independently on its own handshake, and go to B once both have completed, in either order or on the same cycle.
REQ-023 SHALL, in B, hold M_BREADY = 1; on M_BVALID go to IDLE.
REQ-024 SHALL define lane offset OFS as the index of the lowest set bit of the latched STRB, and size as its popcount: 1 = byte, 2 = half, 4 = word.
REQ-025 SHALL drive M_WDATA = latched WDATA << (8*OFS) and M_WSTRB = latched STRB.
REQ-026 SHALL compute load data as M_RDATA >> (8*OFS), truncated to size, zero-extended if LOADUNS = 1 and otherwise sign-extended; word loads pass through unchanged.
REQ-027 SHALL register DONE = 1 for exactly one cycle after the R or B handshake, with ERR = (RESP != 2'b00); RDATA updates only on loads.
REQ-028 SHALL hold RDATA and ERR until the next completion.
REQ-029 SHALL support back-to-back operation, accepting START in the same cycle DONE is high, since the FSM is already in IDLE.
REQ-030 SHALL give minimum latency START -> DONE of 3 cycles when READY/VALID are already asserted; extra slave wait cycles add 1:1.

Reset
REQ-031 SHALL, while RST = 1, immediately (asynchronously) force IDLE, and drive to 0: BUSY, DONE, ERR, RDATA, every M_*VALID and M_*READY, and all address, data and strobe outputs.
REQ-032 SHALL, on RST mid-transaction, abandon the transaction with no DONE pulse, and accept START on the first clock after RST deasserts.

Verification
REQ-033 SHALL verify LB: ADDR = 0x1003, STRB = 1000, LOADUNS = 0, M_RDATA = 0x80AABBCC -> M_ARADDR = 0x1000, RDATA = 0xFFFFFF80, ERR = 0, DONE 3 cycles after START.
REQ-034 SHALL verify LHU: ADDR = 0x2002, STRB = 1100, LOADUNS = 1, M_RDATA = 0xF00D1234 -> RDATA = 0x0000F00D.
REQ-035 SHALL verify SB: ADDR = 0x3001, STRB = 0010, WDATA = 0x000000A5 -> M_WDATA = 0x0000A500, M_WSTRB = 0010; AWREADY 2 cycles before WREADY -> single DONE after BVALID.
REQ-036 SHALL verify error and ignore: load with M_RRESP = 2'b10 -> DONE with ERR = 1; START pulsed while BUSY -> ignored, exactly one transaction issued.
REQ-037 SHALL verify reset mid-operation: RST asserted while in AWW with VALIDs high -> all VALIDs 0 the same cycle, no DONE; new load after release completes normally.
REQ-038 SHALL verify the null request: START with STRB = 0000 -> no VALID asserted, DONE pulses 1 cycle later.

Source files
------------

// File: rtl/core_lsu_ctrl.sv
// rtl/core_lsu_ctrl.sv - single-outstanding load/store controller bridging the pipeline to AXI4-Lite
module core_lsu_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [3:0]  STRB,
    input  logic        LOADUNS,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic [31:0] M_ARADDR,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [31:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY,
    output logic [31:0] M_AWADDR,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  ofs;
    logic [2:0]  size;
    logic [31:0] rd_shift;
    logic [31:0] ld_data;
    logic        aw_fin, w_fin;

    // Lane offset is the lowest strobe bit; size is the number of strobe bits.
    always_comb begin
        ofs = 2'd0;
        if (strb_q[0])      ofs = 2'd0;
        else if (strb_q[1]) ofs = 2'd1;
        else if (strb_q[2]) ofs = 2'd2;
        else if (strb_q[3]) ofs = 2'd3;
    end

    assign size = {2'b00, strb_q[0]} + {2'b00, strb_q[1]} + {2'b00, strb_q[2]} + {2'b00, strb_q[3]};
    assign rd_shift = M_RDATA >> {ofs, 3'b000};

    always_comb begin
        case (size)
            3'd1:    ld_data = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd2:    ld_data = uns_q ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    assign aw_fin = aw_done_q | M_AWREADY;
    assign w_fin  = w_done_q | M_WREADY;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        uns_d     = uns_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    addr_d    = ADDR;
                    strb_d    = STRB;
                    uns_d     = LOADUNS;
                    wdata_d   = WDATA;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (STRB == 4'b0000) done_d = 1'b1;
                    else                 state_d = WE ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                if (M_ARREADY) state_d = S_R;
            end
            S_R: begin
                if (M_RVALID) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = (M_RRESP != 2'b00);
                    rdata_d = ld_data;
                end
            end
            S_AWW: begin
                // Address and data channels complete independently, in either order.
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) state_d = S_B;
            end
            S_B: begin
                if (M_BVALID) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = (M_BRESP != 2'b00);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            strb_q    <= '0;
            uns_q     <= 1'b0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign M_ARADDR  = addr_q & 32'hFFFF_FFFC;
    assign M_AWADDR  = addr_q & 32'hFFFF_FFFC;
    assign M_ARVALID = (state_q == S_AR);
    assign M_RREADY  = (state_q == S_R);
    assign M_AWVALID = (state_q == S_AWW) && !aw_done_q;
    assign M_WVALID  = (state_q == S_AWW) && !w_done_q;
    assign M_BREADY  = (state_q == S_B);
    assign M_WDATA   = wdata_q << {ofs, 3'b000};
    assign M_WSTRB   = strb_q;
endmodule

// File: tb/tb_core_lsu_ctrl.sv
// tb/tb_core_lsu_ctrl.sv - scoreboard bench for core_lsu_ctrl with a delay-configurable AXI4-Lite slave
module tb_core_lsu_ctrl;
    logic        CLK = 1'b0;
    logic        RST, START, WE, LOADUNS;
    logic [31:0] ADDR, WDATA;
    logic [3:0]  STRB;
    logic        BUSY, DONE, ERR;
    logic [31:0] RDATA;
    logic [31:0] M_ARADDR, M_AWADDR, M_WDATA, M_RDATA;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic [1:0]  M_RRESP, M_BRESP;
    logic [3:0]  M_WSTRB;

    core_lsu_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .WE(WE), .ADDR(ADDR), .STRB(STRB),
        .LOADUNS(LOADUNS), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          start;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    int          cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_rresp, cfg_bresp;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] model_rdata = 32'h0;
    logic        model_err = 1'b0;
    int ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (s[i]) return i;
        return 0;
    endfunction

    function automatic int popc(input logic [3:0] s);
        int n = 0;
        for (int i = 0; i < 4; i++) if (s[i]) n++;
        return n;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] bus, input logic [3:0] s, input logic uns);
        int n;
        int o;
        logic [63:0] v;
        logic [63:0] mask;
        n = popc(s);
        o = lowest(s);
        if (n == 4) return bus;
        v    = {32'h0, bus} >> (8 * o);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = v & mask;
        if (!uns && v[8*n-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // AXI4-Lite slave: each channel answers after its configured number of wait cycles.
    initial begin
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
        forever begin
            @(negedge CLK);
            if (M_ARVALID) begin
                M_ARREADY = (ar_cnt >= cfg_ar);
                if (M_ARREADY) begin ar_hs++; chk("araddr", M_ARADDR, exp_addr); end
                ar_cnt++;
            end else begin M_ARREADY = 0; ar_cnt = 0; end
            if (M_RREADY) begin
                M_RVALID = (r_cnt >= cfg_r);
                M_RDATA  = cfg_rdata;
                M_RRESP  = cfg_rresp;
                r_cnt++;
            end else begin M_RVALID = 0; r_cnt = 0; end
            if (M_AWVALID) begin
                M_AWREADY = (aw_cnt >= cfg_aw);
                if (M_AWREADY) begin aw_hs++; chk("awaddr", M_AWADDR, exp_addr); end
                aw_cnt++;
            end else begin M_AWREADY = 0; aw_cnt = 0; end
            if (M_WVALID) begin
                M_WREADY = (w_cnt >= cfg_w);
                if (M_WREADY) begin
                    w_hs++;
                    chk("wdata", M_WDATA, exp_wdata);
                    chk("wstrb", {28'h0, M_WSTRB}, {28'h0, exp_wstrb});
                end
                w_cnt++;
            end else begin M_WREADY = 0; w_cnt = 0; end
            if (M_BREADY) begin
                M_BVALID = (b_cnt >= cfg_b);
                M_BRESP  = cfg_bresp;
                if (M_BVALID) b_hs++;
                b_cnt++;
            end else begin M_BVALID = 0; b_cnt = 0; end
        end
    end

    // Monitor: every DONE pulse is matched against the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && DONE) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: DONE=1 with no request outstanding (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", RDATA, e.rdata);
                chk("err", {31'h0, ERR}, {31'h0, e.err});
                chk("latency", cyc - e.start, e.lat);
            end
        end
    end

    // Called at a negedge; drives START for one cycle and records the expected completion.
    task automatic issue_op(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                            input logic uns, input logic [31:0] wdata, input logic [31:0] bus_rd,
                            input logic [1:0] rresp, input logic [1:0] bresp,
                            input int d_ar, input int d_r, input int d_aw, input int d_w, input int d_b);
        exp_t e;
        cfg_ar = d_ar; cfg_r = d_r; cfg_aw = d_aw; cfg_w = d_w; cfg_b = d_b;
        cfg_rdata = bus_rd; cfg_rresp = rresp; cfg_bresp = bresp;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_wdata = wdata << (8 * lowest(strb));
        exp_wstrb = strb;
        if (strb == 4'b0000) begin
            e.lat = 1;
        end else if (!we) begin
            model_rdata = load_model(bus_rd, strb, uns);
            model_err   = (rresp != 2'b00);
            e.lat = 3 + d_ar + d_r;
        end else begin
            model_err = (bresp != 2'b00);
            e.lat = 3 + ((d_aw > d_w) ? d_aw : d_w) + d_b;
        end
        e.rdata = model_rdata;
        e.err   = model_err;
        e.start = cyc;
        exp_q.push_back(e);
        START = 1; WE = we; ADDR = addr; STRB = strb; LOADUNS = uns; WDATA = wdata;
        @(negedge CLK);
        START = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: BUSY still 1 after %0d cycles", n);
            RST = 1;
            @(negedge CLK);
            RST = 0;
            exp_q.delete();
            model_rdata = 0;
            model_err = 0;
        end
    endtask

    initial begin
        logic [3:0] legal [9];
        int a0, w0, hs0;
        legal = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hF};
        cfg_ar = 0; cfg_r = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0;
        cfg_rdata = 0; cfg_rresp = 0; cfg_bresp = 0;
        exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        RST = 1; START = 0; WE = 0; ADDR = 0; STRB = 0; LOADUNS = 0; WDATA = 0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", {31'h0, BUSY}, 0);
        chk("rst_done", {31'h0, DONE}, 0);
        chk("rst_err", {31'h0, ERR}, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_handshake", {27'h0, M_ARVALID, M_RREADY, M_AWVALID, M_WVALID, M_BREADY}, 0);
        chk("rst_addr", M_ARADDR | M_AWADDR, 0);
        chk("rst_wdata", M_WDATA, 0);
        chk("rst_wstrb", {28'h0, M_WSTRB}, 0);
        RST = 0;
        @(negedge CLK);

        // LB sign-extended from the top lane, zero wait states
        issue_op(0, 32'h1003, 4'b1000, 0, 0, 32'h80AABBCC, 0, 0, 0, 0, 0, 0, 0);
        wait_idle();
        chk("lb_model", model_rdata, 32'hFFFFFF80);
        // LHU zero-extended from the upper half
        issue_op(0, 32'h2002, 4'b1100, 1, 0, 32'hF00D1234, 0, 0, 1, 2, 0, 0, 0);
        wait_idle();
        chk("lhu_model", model_rdata, 32'h0000F00D);
        // SB with AWREADY two cycles ahead of WREADY
        a0 = aw_hs; w0 = w_hs; hs0 = b_hs;
        issue_op(1, 32'h3001, 4'b0010, 0, 32'h000000A5, 0, 0, 0, 0, 0, 0, 2, 1);
        wait_idle();
        chk("sb_wdata_model", exp_wdata, 32'h0000A500);
        chk("sb_aw_count", aw_hs - a0, 1);
        chk("sb_w_count", w_hs - w0, 1);
        chk("sb_b_count", b_hs - hs0, 1);
        // Load with SLVERR response
        issue_op(0, 32'h0040, 4'b1111, 0, 0, 32'h12345678, 2'b10, 0, 0, 0, 0, 0, 0);
        wait_idle();
        // START pulsed repeatedly while busy must be ignored
        a0 = ar_hs; w0 = aw_hs;
        issue_op(0, 32'h5000, 4'b1111, 0, 0, 32'hCAFEF00D, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            START = 1; WE = 1; ADDR = 32'hDEAD0000; STRB = 4'hF; WDATA = 32'h11111111;
            @(negedge CLK);
        end
        START = 0;
        wait_idle();
        chk("ignore_ar_count", ar_hs - a0, 1);
        chk("ignore_aw_count", aw_hs - w0, 0);
        // Null request: no bus traffic, DONE next cycle
        hs0 = ar_hs + aw_hs + w_hs + b_hs;
        issue_op(0, 32'h6000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("null_valids", {29'h0, M_ARVALID, M_AWVALID, M_WVALID}, 0);
        wait_idle();
        @(negedge CLK);
        chk("null_no_bus", ar_hs + aw_hs + w_hs + b_hs - hs0, 0);

        // Reset while in AWW with both VALIDs up
        cfg_aw = 20; cfg_w = 20;
        START = 1; WE = 1; ADDR = 32'h7000; STRB = 4'hF; WDATA = 32'h55AA55AA;
        @(negedge CLK);
        START = 0;
        @(negedge CLK);
        chk("pre_rst_valids", {30'h0, M_AWVALID, M_WVALID}, 32'h3);
        #2 RST = 1;
        #1;
        chk("rst_async_valids", {30'h0, M_AWVALID, M_WVALID}, 0);
        chk("rst_async_busy", {31'h0, BUSY}, 0);
        chk("rst_async_rdata", RDATA, 0);
        model_rdata = 0;
        model_err = 0;
        @(negedge CLK);
        RST = 0;
        issue_op(0, 32'h8001, 4'b0010, 0, 0, 32'h0000FE00, 0, 0, 0, 0, 0, 0, 0);
        wait_idle();

        // Randomized traffic with random wait states and back-to-back starts
        for (int i = 0; i < 80; i++) begin
            logic [3:0] s;
            logic [1:0] rr, br;
            s  = legal[$urandom_range(0, 8)];
            rr = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            br = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
            issue_op(1'($urandom_range(0, 1)), $urandom, s, 1'($urandom_range(0, 1)), $urandom,
                     $urandom, rr, br, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (5) @(negedge CLK);
        chk("pending_expectations", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
